rtr_flit_injector: RTL and testbench
====================================

Name: rtr_flit_injector

Overview:
- Network-interface source stage feeding one router input port. It converts a local word stream into head/body/tail flits and drives one 69-bit input channel of the router.
- Tracks per-VC downstream buffer credits using the 2-bit credit channel returned by the router.
- One instance per router input port; the 5 channel outputs are concatenated into the router's 345-bit input bus.

Parameters:
- NUM_VCS, 2, VCs per port; the channel VC field is one-hot of this width, and the credit VC field is clog2(NUM_VCS) bits.
- BUFFER_DEPTH, 8, flit slots per VC at the router input; this is the reset credit count.
- DATA_WIDTH, 64, flit payload bits.
- ADDR_WIDTH, 4, router address / destination width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- router_address  in  ADDR_WIDTH  this node's address; inserted as the source field of the head flit.
- in_valid  in  1  local word valid.
- in_ready  out  1  local word accepted when in_valid & in_ready.
- in_data  in  DATA_WIDTH  payload word.
- in_last  in  1  marks the final payload word of a packet.
- in_vc  in  clog2(NUM_VCS)  VC for the packet; sampled on the first word only.
- in_dest  in  ADDR_WIDTH  destination; sampled on the first word only.
- channel_out  out  3+NUM_VCS+DATA_WIDTH  flit channel to the router.
- flow_ctrl_in  in  1+clog2(NUM_VCS)  credit return from the router.
- error  out  1  sticky credit-overflow flag.
- idle  out  1  high in IDLE with all credit counters full.

Behaviour:
- Channel format, MSB-first [0:68] at defaults:
  - [0] flit valid.
  - [1] head.
  - [2] tail.
  - [3:4] one-hot VC.
  - [5:68] data.
- Credit format [0:1]:
  - [0] credit valid.
  - [1] VC index.
- Reset (reset=0, asynchronous):
  - State returns to IDLE.
  - channel_out = 0 and in_ready = 0.
  - All credit counters = BUFFER_DEPTH.
  - error = 0 and idle = 1.
- Credit counters: one per VC, width clog2(BUFFER_DEPTH+1).
  - Decrement on a flit sent on that VC.
  - Increment on credit valid for that VC.
  - Both in the same cycle on the same VC: counter is unchanged.
  - A credit arriving while the counter is at BUFFER_DEPTH sets error, which stays set until reset; the counter saturates at BUFFER_DEPTH.
  - A returned credit is usable for sending in the following cycle.
- can_send = counter[active_vc] != 0.
- State machine IDLE / HEAD / BODY:
  - IDLE: in_ready=0. When in_valid=1, latch in_vc and in_dest (the word is not consumed) and go to HEAD.
  - HEAD: in_ready=0. When can_send=1, emit the head flit and go to BODY.
    - Head flit fields: head=1, tail=0.
    - Head flit data: [0:3]=dest, [4:7]=router_address, remainder=0.
  - BODY: in_ready=can_send.
    - On each handshake, emit a flit with head=0, tail=in_last, data=in_data.
    - On in_last, return to IDLE.
    - in_vc and in_dest changes mid-packet are ignored.
- Every packet is 1 head flit plus N>=1 payload flits. in_last on the first word gives a 2-flit packet.
- channel_out is registered:
  - A flit appears the cycle after the send decision.
  - The valid bit is 0 in every cycle with no send; data bits are don't-care when invalid.
- Throughput:
  - 1 flit/cycle while credits are available.
  - IDLE->HEAD costs 1 bubble cycle per packet.
- A VC with 0 credits stalls the whole injector. There is no VC interleaving; packets are sent strictly in order.
- Asserting reset mid-packet abandons the packet. No tail flit is emitted.

Test Plan:
- Reset then idle: channel_out=0, in_ready=0, idle=1, error=0, counters=8.
- 3-word packet on vc=1, dest=4'hA, router_address=4'h3, credits unconstrained.
  - Flits appear on 4 consecutive cycles: head data[0:7]=8'hA3 with VC field=01; body; body; tail.
  - idle=0 while the counter is below 8.
- Credit starvation on vc=0, no credits returned, 12-word packet.
  - Exactly 8 flits are sent (head + 7 body), then in_ready stays 0.
  - One credit is returned; the next flit is sent 2 cycles later.
- Simultaneous send and credit on the same VC for 10 cycles with counter=8: the counter stays 8 and error=0.
- Extra credit on vc=1 at a full counter: error=1 from the next cycle, stays set, and the counter remains 8.
- Reset asserted mid-body: all outputs clear immediately (asynchronously). After release, a new packet starts with a head flit and all counters read 8.

Source files
------------

// File: rtl/rtr_flit_injector.sv
// rtr_flit_injector: network-interface source stage for one router input port.
// Turns a local word stream into head/body/tail flits on a single router input channel and
// tracks per-VC downstream buffer credits returned by the router.
//
// Ports:
//   clk_i              clock
//   rst_ni             asynchronous active-low reset
//   router_address_i   this node's address, placed in the head flit as the source field
//   in_valid_i/in_ready_o/in_data_i/in_last_i   local word stream
//   in_vc_i, in_dest_i packet VC and destination, sampled on the first word only
//   channel_out_o      {valid, head, tail, one-hot VC, data}, registered
//   flow_ctrl_in_i     {credit valid, credit VC index}
//   error_o            sticky credit-overflow flag
//   idle_o             idle with every credit counter full
module rtr_flit_injector #(
   parameter  int unsigned NumVcs      = 2,
   parameter  int unsigned BufferDepth = 8,
   parameter  int unsigned DataWidth   = 64,
   parameter  int unsigned AddrWidth   = 4,
   localparam int unsigned VcW         = (NumVcs > 1) ? $clog2(NumVcs) : 1,
   localparam int unsigned ChW         = 3 + NumVcs + DataWidth,
   localparam int unsigned CntW        = $clog2(BufferDepth + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [AddrWidth-1:0] router_address_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [DataWidth-1:0] in_data_i,
   input  logic                 in_last_i,
   input  logic [VcW-1:0]       in_vc_i,
   input  logic [AddrWidth-1:0] in_dest_i,
   output logic [ChW-1:0]       channel_out_o,
   input  logic [VcW:0]         flow_ctrl_in_i,
   output logic                 error_o,
   output logic                 idle_o
);

   localparam int unsigned HeadPad = DataWidth - 2 * AddrWidth;

   typedef enum logic [1:0] {StIdle, StHead, StBody} state_e;

   state_e                 state_q;
   logic [VcW-1:0]         vc_q;
   logic [AddrWidth-1:0]   dest_q;
   logic [ChW-1:0]         chan_q;
   logic                   error_q, error_d;
   logic [CntW-1:0]        cnt_q [NumVcs];
   logic [CntW-1:0]        cnt_d [NumVcs];

   logic                   can_send;
   logic                   send_body;
   logic                   send;
   logic                   cred_valid;
   logic [VcW-1:0]         cred_vc;
   logic [NumVcs-1:0]      take;
   logic [NumVcs-1:0]      give;
   logic [NumVcs-1:0]      vc_field;
   logic [DataWidth-1:0]   head_data;
   logic                   all_full;

   assign can_send   = (cnt_q[vc_q] != '0);
   assign in_ready_o = (state_q == StBody) && can_send;
   assign send_body  = in_valid_i && in_ready_o;
   assign send       = ((state_q == StHead) && can_send) || send_body;
   assign cred_valid = flow_ctrl_in_i[VcW];
   assign cred_vc    = flow_ctrl_in_i[VcW-1:0];
   assign head_data  = {dest_q, router_address_i, {HeadPad{1'b0}}};

   // The VC field is numbered MSB-first on the channel, so VC 0 sits in the top bit.
   always_comb begin
      vc_field = '0;
      for (int v = 0; v < NumVcs; v++) begin
         vc_field[NumVcs-1-v] = (vc_q == VcW'(v));
      end
   end

   always_comb begin
      take = '0;
      give = '0;
      for (int v = 0; v < NumVcs; v++) begin
         take[v] = send && (vc_q == VcW'(v));
         give[v] = cred_valid && (cred_vc == VcW'(v));
      end
   end

   // A send and a credit on the same VC cancel; a lone credit at a full counter is an overflow.
   always_comb begin
      error_d  = error_q;
      all_full = 1'b1;
      for (int v = 0; v < NumVcs; v++) begin
         cnt_d[v] = cnt_q[v];
         if (take[v] && !give[v]) begin
            cnt_d[v] = cnt_q[v] - 1'b1;
         end else if (give[v] && !take[v]) begin
            if (cnt_q[v] == CntW'(BufferDepth)) begin
               error_d = 1'b1;
            end else begin
               cnt_d[v] = cnt_q[v] + 1'b1;
            end
         end
         if (cnt_q[v] != CntW'(BufferDepth)) begin
            all_full = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         error_q <= 1'b0;
         for (int v = 0; v < NumVcs; v++) begin
            cnt_q[v] <= CntW'(BufferDepth);
         end
      end else begin
         error_q <= error_d;
         for (int v = 0; v < NumVcs; v++) begin
            cnt_q[v] <= cnt_d[v];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         vc_q    <= '0;
         dest_q  <= '0;
         chan_q  <= '0;
      end else begin
         chan_q <= '0;
         unique case (state_q)
            StIdle: begin
               // The first word only seeds VC and destination; it is consumed in StBody.
               if (in_valid_i) begin
                  vc_q    <= in_vc_i;
                  dest_q  <= in_dest_i;
                  state_q <= StHead;
               end
            end
            StHead: begin
               if (can_send) begin
                  chan_q  <= {1'b1, 1'b1, 1'b0, vc_field, head_data};
                  state_q <= StBody;
               end
            end
            StBody: begin
               if (send_body) begin
                  chan_q <= {1'b1, 1'b0, in_last_i, vc_field, in_data_i};
                  if (in_last_i) begin
                     state_q <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign channel_out_o = chan_q;
   assign error_o       = error_q;
   assign idle_o        = (state_q == StIdle) && all_full;

endmodule

// File: tb/tb_rtr_flit_injector.sv
// Scoreboard bench for rtr_flit_injector: expected flits are queued as packets are driven and
// compared as they appear on the channel.
module tb_rtr_flit_injector;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  router_address = 4'h3;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_data = '0;
   logic        in_last = 1'b0;
   logic [0:0]  in_vc = '0;
   logic [3:0]  in_dest = '0;
   logic [68:0] chan;
   logic [1:0]  fc = '0;
   logic        error;
   logic        idle;

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          n_flits = 0;
   int          last_flit_cyc = 0;
   bit          abort = 1'b0;
   logic [68:0] exp_q[$];
   logic [68:0] seen_q[$];
   int          cyc_q[$];

   always #5 clk = ~clk;

   rtr_flit_injector #(
      .NumVcs      (2),
      .BufferDepth (8),
      .DataWidth   (64),
      .AddrWidth   (4)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .router_address_i (router_address),
      .in_valid_i       (in_valid),
      .in_ready_o       (in_ready),
      .in_data_i        (in_data),
      .in_last_i        (in_last),
      .in_vc_i          (in_vc),
      .in_dest_i        (in_dest),
      .channel_out_o    (chan),
      .flow_ctrl_in_i   (fc),
      .error_o          (error),
      .idle_o           (idle)
   );

   task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [68:0] mk_flit(input bit head, input bit tail, input int vc,
                                           input logic [63:0] data);
      logic [1:0] oh;
      oh = (vc == 0) ? 2'b10 : 2'b01;
      return {1'b1, head, tail, oh, data};
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n && chan[68]) begin
         n_flits++;
         last_flit_cyc = cyc;
         seen_q.push_back(chan);
         cyc_q.push_back(cyc);
         if (exp_q.size() == 0) check("unexpected_flit", chan, '0);
         else check("flit", chan, exp_q.pop_front());
      end
   end

   // Call just after a rising edge.
   task automatic send_packet(input int vc, input logic [3:0] dest, input int nwords,
                              input logic [63:0] base);
      logic hs;
      int   waited;
      exp_q.push_back(mk_flit(1'b1, 1'b0, vc, {dest, router_address, 56'h0}));
      for (int w = 0; w < nwords; w++) begin
         exp_q.push_back(mk_flit(1'b0, w == nwords - 1, vc, base + 64'(w)));
      end
      in_vc    = 1'(vc);
      in_dest  = dest;
      in_valid = 1'b1;
      for (int w = 0; w < nwords; w++) begin
         in_data = base + 64'(w);
         in_last = (w == nwords - 1);
         waited  = 0;
         do begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            waited++;
            if (abort) begin
               in_valid = 1'b0;
               in_last  = 1'b0;
               return;
            end
         end while (!hs && waited < 200);
         if (!hs) begin
            check("handshake_timeout", 69'(w), 69'(nwords));
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
         end
         // Mid-packet VC/destination changes must be ignored.
         in_vc   = ~in_vc;
         in_dest = ~dest;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Call just after a rising edge; returns just after a rising edge.
   task automatic credit(input int vc, input int n);
      for (int i = 0; i < n; i++) begin
         fc = {1'b1, 1'(vc)};
         @(posedge clk);
         #1;
      end
      fc = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int t;
      int k;

      // Reset state.
      #12;
      check("rst_chan", chan, '0);
      check("rst_ready", 69'(in_ready), 69'd0);
      check("rst_idle", 69'(idle), 69'd1);
      check("rst_error", 69'(error), 69'd0);
      check("rst_cnt0", 69'(dut.cnt_q[0]), 69'd8);
      check("rst_cnt1", 69'(dut.cnt_q[1]), 69'd8);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_idle", 69'(idle), 69'd1);
      check("post_rst_chan", chan, '0);

      // 3-word packet on VC 1.
      seen_q.delete();
      cyc_q.delete();
      send_packet(1, 4'hA, 3, 64'hA000);
      repeat (2) @(negedge clk);
      check("pkt3_nflits", 69'(cyc_q.size()), 69'd4);
      if (cyc_q.size() == 4) begin
         check("pkt3_consec", 69'(cyc_q[3] - cyc_q[0]), 69'd3);
         check("pkt3_head_byte", 69'(seen_q[0][63:56]), 69'h A3);
         check("pkt3_head_vc", 69'(seen_q[0][65:64]), 69'b01);
         check("pkt3_tail", 69'(seen_q[3][66]), 69'd1);
      end
      check("pkt3_idle_low", 69'(idle), 69'd0);
      check("pkt3_cnt1", 69'(dut.cnt_q[1]), 69'd4);
      @(posedge clk);
      #1;
      credit(1, 4);
      check("pkt3_idle_back", 69'(idle), 69'd1);

      // Credit starvation on VC 0.
      @(posedge clk);
      #1;
      base = n_flits;
      fork
         send_packet(0, 4'h5, 12, 64'h1000);
         begin
            t = 0;
            while (n_flits - base < 8 && t < 100) begin
               @(negedge clk);
               t++;
            end
            check("starve_first8", 69'(n_flits - base), 69'd8);
            repeat (10) begin
               @(negedge clk);
               check("starve_ready_low", 69'(in_ready), 69'd0);
            end
            check("starve_count", 69'(n_flits - base), 69'd8);
            check("starve_cnt0", 69'(dut.cnt_q[0]), 69'd0);
            @(posedge clk);
            #1;
            k = cyc;
            credit(0, 1);
            t = 0;
            while (n_flits - base < 9 && t < 20) begin
               @(negedge clk);
               t++;
            end
            check("credit_latency", 69'(last_flit_cyc - k), 69'd2);
            @(posedge clk);
            #1;
            credit(0, 12);
         end
      join
      repeat (4) @(posedge clk);
      #1;
      check("starve_done_flits", 69'(n_flits - base), 69'd13);
      check("starve_cnt_restored", 69'(dut.cnt_q[0]), 69'd8);
      check("starve_idle", 69'(idle), 69'd1);
      check("starve_error", 69'(error), 69'd0);

      // Send and credit on the same VC in the same cycles, counter full.
      @(posedge clk);
      #1;
      fork
         send_packet(0, 4'h9, 10, 64'hB000);
         begin
            @(posedge clk);
            #1;
            fc = 2'b10;
            repeat (11) begin
               @(posedge clk);
               #1;
               check("simul_cnt", 69'(dut.cnt_q[0]), 69'd8);
            end
            fc = '0;
         end
      join
      repeat (2) @(negedge clk);
      check("simul_error", 69'(error), 69'd0);

      // Extra credit at a full counter.
      @(posedge clk);
      #1;
      fc = 2'b11;
      @(negedge clk);
      check("ovf_error_before", 69'(error), 69'd0);
      @(posedge clk);
      #1;
      fc = '0;
      check("ovf_error_set", 69'(error), 69'd1);
      check("ovf_cnt1", 69'(dut.cnt_q[1]), 69'd8);
      repeat (5) @(posedge clk);
      #1;
      check("ovf_error_sticky", 69'(error), 69'd1);

      // Reset in the middle of a packet body.
      base = n_flits;
      fork
         send_packet(0, 4'h2, 6, 64'hC000);
         begin
            t = 0;
            while (n_flits - base < 3 && t < 50) begin
               @(negedge clk);
               t++;
            end
            #2;
            rst_n = 1'b0;
            abort = 1'b1;
            exp_q.delete();
            #1;
            check("mid_rst_chan", chan, '0);
            check("mid_rst_ready", 69'(in_ready), 69'd0);
            check("mid_rst_error", 69'(error), 69'd0);
            check("mid_rst_idle", 69'(idle), 69'd1);
            check("mid_rst_cnt0", 69'(dut.cnt_q[0]), 69'd8);
         end
      join
      abort = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rel_cnt0", 69'(dut.cnt_q[0]), 69'd8);
      check("rel_cnt1", 69'(dut.cnt_q[1]), 69'd8);
      seen_q.delete();
      send_packet(1, 4'h7, 1, 64'hD00D);
      repeat (2) @(negedge clk);
      check("rel_nflits", 69'(seen_q.size()), 69'd2);
      if (seen_q.size() == 2) begin
         check("rel_head", 69'(seen_q[0][67]), 69'd1);
         check("rel_tail", 69'(seen_q[1][66]), 69'd1);
      end
      check("rel_cnt1_used", 69'(dut.cnt_q[1]), 69'd6);
      check("sb_empty", 69'(exp_q.size()), 69'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
